// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: data width, depth and the reader FSM state type.
// Imported by fifo_reader and by FIFO benches.
package fifo_pkg;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 16;
  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POP     = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_PRESENT = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fifo_reader.sv
// Pops bytes from a registered-flag FIFO and presents them on a valid/ready port.
// Optional burst mode is enabled by defining FIFO_READER_BURST_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for en, data in the FIFO and a burst start condition
// ST_POP     | pop_out pulse; head byte captured into m_data on exit
// ST_SETTLE  | one cycle for the FIFO empty flag to reflect the pop
// ST_PRESENT | m_valid held with stable m_data until m_ready
module fifo_reader
  import fifo_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               pop_out,
  input  logic [DATA_W-1:0]  fifo_dout,
  input  logic               fifo_empty,
  input  logic               fifo_threshold_trigger,
  input  logic [BURST_W-1:0] burst_len,
  output logic [DATA_W-1:0]  m_data,
  input  logic               m_ready,
  output logic               m_valid,
  output logic               busy,
  output logic               burst_short
);

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic              w_hs;
  logic              w_can_start;
  logic              w_can_cont;

  assign w_hs = (r_state == ST_PRESENT) && m_ready;

`ifdef FIFO_READER_BURST_EN
  logic [BURST_W-1:0] r_burst_cnt;
  logic               r_burst_short;

  assign w_can_start = fifo_threshold_trigger;
  assign w_can_cont  = (r_burst_cnt != '0);

  // Counter holds bytes remaining after the one currently presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_cnt   <= '0;
      r_burst_short <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_POP)) begin
        r_burst_cnt <= burst_len;
      end else if (w_hs && (r_burst_cnt != '0)) begin
        r_burst_cnt <= r_burst_cnt - 1'b1;
      end
      if (w_hs && (r_burst_cnt != '0) && fifo_empty) begin
        r_burst_short <= 1'b1;
      end
    end
  end

  assign burst_short = r_burst_short;
`else
  logic w_unused_burst;

  assign w_can_start    = 1'b1;
  assign w_can_cont     = 1'b1;
  assign burst_short    = 1'b0;
  assign w_unused_burst = ^{burst_len, fifo_threshold_trigger};
`endif

  always_comb begin
    w_state_nxt = r_state;
    pop_out     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en && !fifo_empty && w_can_start) begin
          w_state_nxt = ST_POP;
        end
      end
      ST_POP: begin
        pop_out     = 1'b1;
        w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (m_ready) begin
          if (en && !fifo_empty && w_can_cont) begin
            w_state_nxt = ST_POP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // fifo_dout still shows the pre-pop head during POP; capture it on that exit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_POP) begin
        r_data <= fifo_dout;
      end
    end
  end

  assign m_data  = r_data;
  assign m_valid = (r_state == ST_PRESENT);
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port en  input  1  enable; gates new pops only.
REQ-004 SHALL have port pop_out  output  1  pop request to FIFO pop_in; one-cycle pulse.
REQ-005 SHALL have port fifo_dout  input  8  FIFO head-of-queue data, valid while fifo_empty low.
REQ-006 SHALL have port fifo_empty  input  1  FIFO empty flag, registered by FIFO, one-cycle lag after pop.
REQ-007 SHALL have port fifo_threshold_trigger  input  1  FIFO threshold flag.
REQ-008 SHALL have port burst_len  input  4  burst size minus one; sampled at burst start.
REQ-009 SHALL have port m_data  output  8  downstream byte.
REQ-010 SHALL have port m_valid  output  1  downstream byte valid.
REQ-011 SHALL have port m_ready  input  1  downstream accept; transfer when m_valid & m_ready.
REQ-012 SHALL have port busy  output  1  high in any state except IDLE.
REQ-013 SHALL have port burst_short  output  1  sticky: burst ended early on FIFO empty.

Function
REQ-014 SHALL implement FSM states IDLE, POP, SETTLE, PRESENT.
REQ-015 SHALL go IDLE->POP when en=1 and fifo_empty=0 (plus burst start condition, REQ-027).
REQ-016 SHALL assert pop_out=1 only in POP; POP lasts exactly one cycle, then SETTLE.
REQ-017 SHALL capture fifo_dout into m_data on the clock edge leaving POP (pre-shift head value).
REQ-018 SHALL spend exactly one cycle in SETTLE (FIFO flag update), then PRESENT.
REQ-019 SHALL hold m_valid=1 and m_data stable throughout PRESENT until m_valid & m_ready.
REQ-020 SHALL, on handshake in PRESENT, go to POP if en=1, fifo_empty=0 and continuation allowed (REQ-028), else IDLE.
REQ-021 SHALL give latency: pop_out in cycle k, m_valid first high in cycle k+2; max throughput one byte per 3 cycles.
REQ-022 SHALL, on en deasserting mid-operation, finish the held byte's handshake, then go IDLE without a further pop.
REQ-023 SHALL never assert pop_out while fifo_empty=1 or m_valid=1.
REQ-024 SHALL keep m_data unchanged outside the POP->SETTLE capture edge.

Reset
REQ-025 SHALL on rst=1 at a clock edge force state IDLE, pop_out=0, m_valid=0, m_data=8'h00, busy=0, burst_short=0, burst counter=0.
REQ-026 SHALL discard a held byte on reset mid-operation; rst has priority over all other inputs.

Configuration
REQ-027 SHALL with FIFO_READER_BURST_EN defined start a burst only when fifo_threshold_trigger=1 and fifo_empty=0, loading a 4-bit remaining counter with burst_len (burst = burst_len+1 bytes, 1..16).
REQ-028 SHALL with FIFO_READER_BURST_EN defined decrement the counter per handshake, return to IDLE when a handshake occurs with counter=0, and set burst_short=1 if fifo_empty=1 at a handshake with counter>0.
REQ-029 SHALL without FIFO_READER_BURST_EN drain whenever fifo_empty=0, ignore burst_len and fifo_threshold_trigger, tie burst_short=0; port list identical in both builds.

Structure
REQ-030 SHALL place DATA_W=8, DEPTH=16 and the FSM state enum typedef in shared package fifo_pkg, also importable by fifo benches.
REQ-031 SHALL be a single module with no sub-modules.

Verification
REQ-032 SHALL cover single byte: FIFO holds 8'hA5, en=1, m_ready=1 -> one pop_out pulse, m_valid at k+2 with m_data=8'hA5, then IDLE, busy=0.
REQ-033 SHALL cover backpressure: m_ready=0 for 5 cycles with 8'h3C held -> m_valid stays 1, m_data=8'h3C stable, no pop_out, transfer on m_ready=1.
REQ-034 SHALL cover drain order: push 8'h01..8'h04, default build -> m_data sequence 01,02,03,04, exactly 4 pop_out pulses, no pop while empty.
REQ-035 SHALL cover burst (macro on): threshold=4, burst_len=3, push 6 bytes -> no pop until trigger, exactly 4 bytes out, IDLE, burst_short=0.
REQ-036 SHALL cover short burst (macro on): burst_len=7, 5 bytes available -> 5 bytes out, burst_short=1 and held until rst.
REQ-037 SHALL cover reset mid-PRESENT: rst=1 one cycle -> next edge m_valid=0, m_data=8'h00, state IDLE, burst_short=0.
